adc128s022_emulator: RTL and testbench

Synthesizable SPI responder that emulates the ADC128S022 audio ADC, the other end of the audio SPI link driven by the audio SPI controller. It lets the audio capture path run without the physical chip: the controller's CS/SCLK/DIN outputs are routed to this block, and its DOUT is routed back in place of `ADC_SDAT`. Each channel returns a deterministic per-channel ramp, so the embedded audio words in the captured stream can be checked bit-exactly. It runs on the 40 MHz ADC clock and oversamples the SPI lines.

---
 rtl/adc128s022_emulator.sv | 115 +++++++++++
 tb/tb_adc128s022_emulator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/adc128s022_emulator.sv
// adc128s022_emulator: SPI responder that stands in for the ADC128S022, returning a per-channel ramp on DOUT.
module adc128s022_emulator #(
   parameter int STEP        = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_spi_cs_n,
   input  logic        i_spi_sclk,
   input  logic        i_spi_din,
   output logic        o_spi_dout,
   output logic        o_spi_dout_oe,
   output logic [15:0] o_frame_count,
   output logic        o_frame_error,
   output logic [2:0]  o_last_channel
);
   typedef enum logic {S_IDLE, S_FRAME} state_t;
   state_t r_state, w_state_next;
   logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_din_sync;
   logic        r_cs_d, r_sclk_d;
   logic [3:0]  r_bit_cnt;
   logic [2:0]  r_addr, r_addr_next;
   logic [15:0] r_shift;
   logic        r_dout;
   logic [15:0] r_frame_count;
   logic        r_frame_error;
   logic [2:0]  r_last_channel;
   logic [11:0] r_ramp [8];
   logic        w_cs, w_sclk, w_din;
   logic        w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
   logic        w_run, w_start, w_reload, w_shift, w_sample_din, w_frame_done;
   logic [15:0] w_ramp_word;

   assign w_cs         = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
   assign w_din        = r_din_sync[SYNC_STAGES-1];
   assign w_cs_fall    = r_cs_d & ~w_cs;
   assign w_cs_rise    = ~r_cs_d & w_cs;
   assign w_sclk_rise  = ~r_sclk_d & w_sclk;
   assign w_sclk_fall  = r_sclk_d & ~w_sclk;
   // A frame only starts from a CS falling edge seen in idle, so a reset while CS is low stays idle.
   assign w_start      = w_cs_fall & (r_state == S_IDLE);
   assign w_run        = (r_state == S_FRAME) & ~w_cs;
   assign w_reload     = w_run & w_sclk_fall & (r_bit_cnt == 4'd0);
   assign w_shift      = w_run & w_sclk_fall & (r_bit_cnt != 4'd0);
   assign w_sample_din = w_run & w_sclk_rise & (r_bit_cnt >= 4'd2) & (r_bit_cnt <= 4'd4);
   assign w_frame_done = w_run & w_sclk_rise & (r_bit_cnt == 4'd15);
   assign w_ramp_word  = {4'b0000, r_ramp[r_addr]};

   assign o_spi_dout     = r_dout;
   assign o_spi_dout_oe  = (r_state == S_FRAME);
   assign o_frame_count  = r_frame_count;
   assign o_frame_error  = r_frame_error;
   assign o_last_channel = r_last_channel;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_cs_sync   <= '0;
         r_sclk_sync <= '0;
         r_din_sync  <= '0;
         r_cs_d      <= 1'b0;
         r_sclk_d    <= 1'b0;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
         r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], i_spi_din};
         r_cs_d      <= w_cs;
         r_sclk_d    <= w_sclk;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_IDLE;
      else r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (r_state == S_IDLE && w_cs_fall) w_state_next = S_FRAME;
      if (r_state == S_FRAME && w_cs) w_state_next = S_IDLE;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_bit_cnt      <= 4'd0;
         r_addr         <= 3'd0;
         r_addr_next    <= 3'd0;
         r_shift        <= 16'd0;
         r_dout         <= 1'b0;
         r_frame_count  <= 16'd0;
         r_frame_error  <= 1'b0;
         r_last_channel <= 3'd0;
         for (int n = 0; n < 8; n++) r_ramp[n] <= 12'(n << 9);
      end else begin
         r_bit_cnt <= !w_run ? 4'd0 : w_sclk_rise ? r_bit_cnt + 4'd1 : r_bit_cnt;
         if (w_sample_din) r_addr_next <= {r_addr_next[1:0], w_din};
         if (w_frame_done) begin
            r_frame_count        <= r_frame_count + 16'd1;
            r_last_channel       <= r_addr;
            r_ramp[r_addr]       <= r_ramp[r_addr] + 12'(STEP);
            r_addr               <= r_addr_next;
         end
         if (w_start || w_reload) begin
            r_shift <= w_ramp_word;
            r_dout  <= w_ramp_word[15];
         end else if (w_shift) begin
            r_shift <= {r_shift[14:0], 1'b0};
            r_dout  <= r_shift[14];
         end else if (w_cs) begin
            r_dout  <= 1'b0;
         end
         if (w_cs_rise && r_bit_cnt != 4'd0) r_frame_error <= 1'b1;
      end
   end
endmodule

// File: tb/tb_adc128s022_emulator.sv
// tb_adc128s022_emulator: drives SPI frames and scoreboards the captured DOUT words against hand-computed ramp values.
module tb_adc128s022_emulator;
   typedef struct {
      logic [15:0] word;
      logic [2:0]  ch;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs_n = 1'b1;
   logic        sclk = 1'b1;
   logic        din = 1'b0;
   logic        dout, dout_oe, frame_error;
   logic [15:0] frame_count;
   logic [2:0]  last_channel;
   logic [15:0] cap = 16'd0;
   logic [15:0] prev_count = 16'd0;
   exp_t        q[$];
   int          n_checks = 0;
   int          n_fail = 0;

   adc128s022_emulator dut (
      .i_clock(clk),
      .i_reset(rst),
      .i_spi_cs_n(cs_n),
      .i_spi_sclk(sclk),
      .i_spi_din(din),
      .o_spi_dout(dout),
      .o_spi_dout_oe(dout_oe),
      .o_frame_count(frame_count),
      .o_frame_error(frame_error),
      .o_last_channel(last_channel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [15:0] word, input logic [2:0] ch, input logic [15:0] cnt);
      exp_t e;
      e.word = word;
      e.ch   = ch;
      e.cnt  = cnt;
      q.push_back(e);
   endtask

   task automatic cs_low();
      @(negedge clk);
      cs_n = 1'b0;
      wait_clk(4);
   endtask

   task automatic cs_high();
      wait_clk(4);
      cs_n = 1'b1;
      wait_clk(8);
   endtask

   task automatic sclk_bits(input logic [2:0] addr, input int n);
      for (int i = 0; i < n; i++) begin
         din  = (i == 2) ? addr[2] : (i == 3) ? addr[1] : (i == 4) ? addr[0] : 1'b0;
         sclk = 1'b0;
         wait_clk(4);
         sclk = 1'b1;
         wait_clk(4);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wait_clk(4);
      rst = 1'b0;
      wait_clk(6);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " dout"}, 32'(dout), 32'h0);
      chk({tag, " oe"}, 32'(dout_oe), 32'h0);
      chk({tag, " frame_count"}, 32'(frame_count), 32'h0);
      chk({tag, " frame_error"}, 32'(frame_error), 32'h0);
      chk({tag, " last_channel"}, 32'(last_channel), 32'h0);
   endtask

   always @(posedge sclk) if (!cs_n) cap = {cap[14:0], dout};

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (frame_count != prev_count) begin
            if (frame_count == prev_count + 16'd1) begin
               if (q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_frame: got count %0d expected no frame", frame_count);
               end else begin
                  e = q.pop_front();
                  chk("dout_word", 32'(cap), 32'(e.word));
                  chk("frame_count", 32'(frame_count), 32'(e.cnt));
                  chk("last_channel", 32'(last_channel), 32'(e.ch));
               end
            end
            prev_count = frame_count;
         end
      end
   end

   initial begin
      wait_clk(5);
      rst = 1'b0;
      wait_clk(6);
      chk_reset_state("reset");

      cs_low();
      chk("oe_in_frame", 32'(dout_oe), 32'h1);
      push(16'h0000, 3'd0, 16'd1);
      sclk_bits(3'd3, 16);
      cs_high();
      chk("oe_after_frame", 32'(dout_oe), 32'h0);
      cs_low();
      push(16'h0600, 3'd3, 16'd2);
      sclk_bits(3'd0, 16);
      cs_high();

      do_reset();
      chk_reset_state("reset2");
      cs_low();
      push(16'h0000, 3'd0, 16'd1);
      sclk_bits(3'd0, 16);
      push(16'h0001, 3'd0, 16'd2);
      sclk_bits(3'd1, 16);
      push(16'h0200, 3'd1, 16'd3);
      sclk_bits(3'd0, 16);
      push(16'h0002, 3'd0, 16'd4);
      sclk_bits(3'd1, 16);
      push(16'h0201, 3'd1, 16'd5);
      sclk_bits(3'd0, 16);
      push(16'h0003, 3'd0, 16'd6);
      sclk_bits(3'd1, 16);
      cs_high();
      chk("stream_count", 32'(frame_count), 32'd6);

      cs_low();
      sclk_bits(3'd3, 7);
      cs_high();
      chk("abort_error", 32'(frame_error), 32'h1);
      chk("abort_count", 32'(frame_count), 32'd6);
      chk("abort_last", 32'(last_channel), 32'd0);

      cs_low();
      push(16'h0202, 3'd1, 16'd7);
      sclk_bits(3'd7, 16);
      for (int k = 0; k <= 512; k++) begin
         push(16'((12'hE00 + 12'(k)) & 12'hFFF), 3'd7, 16'(8 + k));
         sclk_bits(3'd7, 16);
      end
      cs_high();
      chk("wrap_count", 32'(frame_count), 32'd520);
      chk("sticky_error", 32'(frame_error), 32'h1);

      cs_low();
      sclk_bits(3'd0, 9);
      sclk = 1'b0;
      wait_clk(2);
      do_reset();
      chk_reset_state("mid_reset");
      sclk_bits(3'd0, 16);
      wait_clk(6);
      chk("ignored_count", 32'(frame_count), 32'd0);
      chk("ignored_oe", 32'(dout_oe), 32'h0);
      cs_high();
      cs_low();
      push(16'h0000, 3'd0, 16'd1);
      sclk_bits(3'd0, 16);
      cs_high();
      wait_clk(10);
      chk("pending_frames", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
